// File: rtl/ov7670_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ov7670_pkg
// Purpose  : Shared types and constants for the OV7670 SCCB write master.
// Revision : 1.0 - initial release
// ============================================================================
package ov7670_pkg;

  // Write-master sequencing states.
  typedef enum logic [2:0] {
    ST_SETTLE   = 3'd0,
    ST_LOAD     = 3'd1,
    ST_START    = 3'd2,
    ST_SHIFT    = 3'd3,
    ST_STOP     = 3'd4,
    ST_WAIT     = 3'd5,
    ST_NEXT     = 3'd6,
    ST_FINISHED = 3'd7
  } sccb_state_t;

  localparam logic [7:0]  OV7670_SCCB_ID = 8'h42;
  localparam logic [7:0]  REG_COM7       = 8'h12;
  localparam int          COM7_RESET_BIT = 7;
  localparam logic [15:0] INIT_DONE_WORD = 16'hffff;

  // Sequencer output lags `continue` (and reset release) by this many cycles.
  localparam int SETTLE_CYCLES = 2;
  // 3 bytes x (8 data + 1 don't-care) bit slots.
  localparam int SCCB_SLOTS    = 27;

  // A COM7 write with bit 7 set soft-resets the sensor and needs a long pause.
  function automatic logic is_soft_reset(input logic [15:0] word);
    return (word[15:8] == REG_COM7) && word[COM7_RESET_BIT];
  endfunction

endpackage
`default_nettype wire

// File: rtl/ov7670_sccb_write_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : sccb_tick_gen
// Purpose  : Quarter-bit tick divider with a 2-bit phase counter for SCCB.
// Revision : 1.0 - initial release
// ============================================================================
module sccb_tick_gen #(
  parameter int DIV = 2
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_en,
  output logic       o_tick,
  output logic [1:0] o_phase
);

  localparam int             c_cw   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [c_cw-1:0] c_last = c_cw'(DIV - 1);

  logic [c_cw-1:0] r_cnt;
  logic [1:0]      r_phase;

  assign o_tick  = i_en && (r_cnt == c_last);
  assign o_phase = r_phase;

  // Divider and phase counter; both parked at zero while disabled.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt   <= '0;
      r_phase <= '0;
    end else if (!i_en) begin
      r_cnt   <= '0;
      r_phase <= '0;
    end else if (o_tick) begin
      r_cnt   <= '0;
      r_phase <= r_phase + 2'd1;
    end else begin
      r_cnt   <= r_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ov7670_sccb_write.sv
`default_nettype none
// ============================================================================
// Module   : ov7670_sccb_write
// Purpose  : SCCB 3-phase write master fed by the OV7670 register-init
//            sequencer; raises config_done once the sequencer is exhausted.
// Revision : 1.0 - initial release
// ============================================================================
module ov7670_sccb_write
  import ov7670_pkg::*;
#(
  parameter int         CLK_FREQ          = 25000000,
  parameter int         SCCB_FREQ         = 100000,
  parameter logic [7:0] DEVICE_ID         = OV7670_SCCB_ID,
  parameter int         RESET_WAIT_CYCLES = 25000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [15:0] i_data,
  input  logic        i_done,
  output logic        o_continue,
  output logic        o_sio_c,
  output logic        o_sio_d_out,
  output logic        o_sio_d_oe,
  output logic        o_busy,
  output logic        o_config_done
);

  localparam int c_div      = CLK_FREQ / (4 * SCCB_FREQ);
  localparam int c_bus_free = 4 * c_div;
  localparam int c_wait_max = (RESET_WAIT_CYCLES > c_bus_free) ? RESET_WAIT_CYCLES : c_bus_free;
  localparam int c_cnt_w    = $clog2(c_wait_max + 1);

  if (c_div < 2) begin : g_div_check
    $error("ov7670_sccb_write: CLK_FREQ/(4*SCCB_FREQ) must be >= 2");
  end

  sccb_state_t        r_state, w_next;
  logic [c_cnt_w-1:0] r_cnt;
  logic [23:0]        r_shift;
  logic [15:0]        r_word;
  logic [4:0]         r_slot;
  logic [3:0]         r_bit;
  logic               r_busy, r_continue, r_config_done;
  logic               r_sio_c, r_sio_d, r_sio_oe;
  logic               w_c, w_d, w_oe;
  logic               w_en, w_tick, w_phase_end, w_dc;
  logic [1:0]         w_phase;
  logic [c_cnt_w-1:0] w_wait_last;

  assign w_en        = (r_state == ST_START) || (r_state == ST_SHIFT) || (r_state == ST_STOP);
  assign w_phase_end = w_tick && (w_phase == 2'd3);
  assign w_dc        = (r_bit == 4'd8);
  assign w_wait_last = is_soft_reset(r_word) ? c_cnt_w'(RESET_WAIT_CYCLES - 1)
                                             : c_cnt_w'(c_bus_free - 1);

  sccb_tick_gen #(.DIV(c_div)) u_tick_gen (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_en    (w_en),
    .o_tick  (w_tick),
    .o_phase (w_phase)
  );

  // FSM state register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= ST_SETTLE;
    else         r_state <= w_next;
  end

  // Next-state and per-phase bus levels (idle bus unless shifting a frame).
  always_comb begin
    w_next = r_state;
    w_c    = 1'b1;
    w_d    = 1'b1;
    w_oe   = 1'b1;
    case (r_state)
      ST_SETTLE:   if (r_cnt == c_cnt_w'(SETTLE_CYCLES - 1)) w_next = ST_LOAD;
      ST_LOAD:     w_next = i_done ? ST_FINISHED : ST_START;
      ST_START: begin
        w_d = (w_phase == 2'd0);
        w_c = (w_phase != 2'd3);
        if (w_phase_end) w_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        w_c  = (w_phase == 2'd1) || (w_phase == 2'd2);
        w_oe = !w_dc;
        w_d  = w_dc ? 1'b1 : r_shift[23];
        if (w_phase_end && (r_slot == 5'(SCCB_SLOTS - 1))) w_next = ST_STOP;
      end
      ST_STOP: begin
        w_d = w_phase[1];
        w_c = (w_phase != 2'd0);
        if (w_phase_end) w_next = ST_WAIT;
      end
      ST_WAIT:     if (r_cnt == w_wait_last) w_next = ST_NEXT;
      ST_NEXT:     w_next = ST_SETTLE;
      ST_FINISHED: w_next = ST_FINISHED;
      default:     w_next = ST_SETTLE;
    endcase
  end

  // Dwell counter for SETTLE and WAIT, cleared on every state change.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)                                         r_cnt <= '0;
    else if (w_next != r_state)                          r_cnt <= '0;
    else if (r_state == ST_SETTLE || r_state == ST_WAIT) r_cnt <= r_cnt + 1'b1;
  end

  // Frame latch/shift, status flags and registered (glitch-free) bus outputs.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_shift       <= '0;
      r_word        <= '0;
      r_slot        <= '0;
      r_bit         <= '0;
      r_busy        <= 1'b0;
      r_continue    <= 1'b0;
      r_config_done <= 1'b0;
      r_sio_c       <= 1'b1;
      r_sio_d       <= 1'b1;
      r_sio_oe      <= 1'b1;
    end else begin
      r_continue <= (r_state == ST_NEXT);
      r_sio_c    <= w_c;
      r_sio_d    <= w_d;
      r_sio_oe   <= w_oe;
      case (r_state)
        ST_LOAD: begin
          if (i_done) begin
            r_config_done <= 1'b1;
          end else begin
            r_shift <= {DEVICE_ID, i_data};
            r_word  <= i_data;
            r_slot  <= '0;
            r_bit   <= '0;
            r_busy  <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (w_phase_end) begin
            r_slot <= r_slot + 5'd1;
            if (w_dc) begin
              r_bit <= '0;
            end else begin
              r_bit   <= r_bit + 4'd1;
              r_shift <= {r_shift[22:0], 1'b0};
            end
          end
        end
        ST_NEXT: r_busy <= 1'b0;
        default: ;
      endcase
    end
  end

  assign o_continue    = r_continue;
  assign o_sio_c       = r_sio_c;
  assign o_sio_d_out   = r_sio_d;
  assign o_sio_d_oe    = r_sio_oe;
  assign o_busy        = r_busy;
  assign o_config_done = r_config_done;

endmodule
`default_nettype wire

// File: tb/tb_ov7670_sccb_write.sv
`default_nettype none
// ============================================================================
// Module   : tb_ov7670_sccb_write
// Purpose  : Self-checking bench for ov7670_sccb_write (DIV = 2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ov7670_sccb_write;

  localparam int CLK_FREQ  = 800;
  localparam int SCCB_FREQ = 100;
  localparam int DIV       = CLK_FREQ / (4 * SCCB_FREQ);
  localparam int RST_WAIT  = 50;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] data = 16'h0000;
  logic        done = 1'b0;
  logic        cont, sio_c, sio_d_out, sio_d_oe, busy, config_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  ov7670_sccb_write #(
    .CLK_FREQ(CLK_FREQ), .SCCB_FREQ(SCCB_FREQ),
    .DEVICE_ID(8'h42), .RESET_WAIT_CYCLES(RST_WAIT)
  ) u_dut (
    .i_clk(clk), .i_reset(reset), .i_data(data), .i_done(done),
    .o_continue(cont), .o_sio_c(sio_c), .o_sio_d_out(sio_d_out),
    .o_sio_d_oe(sio_d_oe), .o_busy(busy), .o_config_done(config_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- bus decoder (observes the SCCB pins only) ----------------
  logic        prev_c = 1'b1, prev_d = 1'b1, prev_cont = 1'b0;
  logic        in_txn = 1'b0;
  int          nb = 0, edges = 0, cont_hi = 0;
  logic [26:0] bits_v, oes_v;
  logic [23:0] q_word[$];
  logic [26:0] q_oe[$];
  int          q_nb[$];
  int          pulse_q[$];

  always @(negedge clk) begin
    if (reset) begin
      in_txn = 1'b0; nb = 0; edges = 0; cont_hi = 0;
      q_word.delete(); q_oe.delete(); q_nb.delete(); pulse_q.delete();
    end else begin
      if (in_txn && sio_c && !prev_c) begin
        if (nb < 27) begin
          bits_v[26-nb] = sio_d_out;
          oes_v[26-nb]  = sio_d_oe;
        end
        nb++;
      end
      if (sio_c && prev_c && sio_d_oe) begin
        if (prev_d && !sio_d_out) begin
          in_txn = 1'b1; nb = 0; bits_v = '0; oes_v = '0;
        end else if (in_txn && !prev_d && sio_d_out) begin
          q_word.push_back({bits_v[26:19], bits_v[17:10], bits_v[8:1]});
          q_oe.push_back(oes_v);
          q_nb.push_back(nb);
          in_txn = 1'b0;
        end
      end
      if (sio_c != prev_c) edges++;
      if (cont) begin
        cont_hi++;
        if (!prev_cont) pulse_q.push_back(cyc);
      end
    end
    prev_c = sio_c; prev_d = sio_d_out; prev_cont = cont;
  end

  // ---------------- reference model ----------------
  // Post-stop pause: long after a COM7 soft reset, otherwise one bit period.
  function automatic int exp_wait(input logic [15:0] w);
    return (w[15:8] == 8'h12 && w[7]) ? RST_WAIT : 4 * DIV;
  endfunction

  // Cycles from reset release / previous pulse to the continue pulse:
  // 2 settle + 1 load, 29 bit periods, the pause, then the pulse itself.
  function automatic int exp_gap(input logic [15:0] w);
    return 2 + 1 + 29 * 4 * DIV + exp_wait(w) + 1;
  endfunction

  localparam logic [26:0] EXP_OE = 27'b111111110_111111110_111111110;

  function automatic logic [31:0] word_at(input int i);
    return (q_word.size() > i) ? {8'h00, q_word[i]} : 32'hxxxxxxxx;
  endfunction
  function automatic logic [31:0] oe_at(input int i);
    return (q_oe.size() > i) ? {5'h0, q_oe[i]} : 32'hxxxxxxxx;
  endfunction
  function automatic logic [31:0] nb_at(input int i);
    return (q_nb.size() > i) ? q_nb[i] : 32'hxxxxxxxx;
  endfunction
  function automatic logic [31:0] pulse_at(input int i);
    return (pulse_q.size() > i) ? pulse_q[i] : 32'hxxxxxxxx;
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
  endtask

  task automatic wait_pulses(input int n, input int budget, input string tag);
    int k = 0;
    while (pulse_q.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    check(tag, pulse_q.size(), n);
  endtask

  // One write from reset release; data switches to w_late mid-frame.
  task automatic single_txn(input logic [15:0] w, input logic [15:0] w_late, input string tag);
    int r;
    do_reset();
    data = w; done = 1'b0;
    reset = 1'b0; r = cyc;
    tick(2);
    check({tag, "_busy_load"}, busy, 1'b0);
    tick(58);
    check({tag, "_busy_mid"}, busy, 1'b1);
    data = w_late;
    wait_pulses(1, exp_gap(w) + 40, {tag, "_pulse_seen"});
    check({tag, "_pulse_time"}, pulse_at(0), r + exp_gap(w));
    check({tag, "_busy_after"}, busy, 1'b0);
    check({tag, "_word"}, word_at(0), {8'h00, 8'h42, w});
    check({tag, "_oe"}, oe_at(0), {5'h0, EXP_OE});
    check({tag, "_edges"}, nb_at(0), 28);
    tick(3);
    check({tag, "_pulse_width"}, cont_hi, 1);
  endtask

  logic [15:0] tbl [11] = '{16'h1280, 16'h1280, 16'h1101, 16'h0c04, 16'h3e19, 16'h4010,
                            16'h3a04, 16'h1438, 16'h4fb3, 16'hb084, 16'ha202};

  initial begin
    int          r, idx, due, k, edges_at_end, prev;
    logic [15:0] w;

    // Reset state.
    #2 reset = 1'b1;
    tick(3);
    check("rst_bus", {sio_c, sio_d_out, sio_d_oe}, 3'b111);
    check("rst_continue", cont, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_config_done", config_done, 1'b0);

    // Basic write, COM7 soft reset (long pause), COM7 without reset bit.
    single_txn(16'h1101, 16'h1101, "w1101");
    single_txn(16'h1280, 16'h1280, "w1280");
    single_txn(16'h1200, 16'h1200, "w1200");

    // Late change of data must not reach the bus.
    single_txn(16'h1101, 16'h3e00, "late_data");

    // Randomized words, half of them aimed at COM7.
    for (int i = 0; i < 4; i++) begin
      w[15:8] = ($urandom_range(0, 1) == 1) ? 8'h12 : 8'($urandom);
      w[7:0]  = 8'($urandom);
      single_txn(w, w, "rand");
    end

    // Reset while shifting slot 12.
    do_reset();
    data = 16'h1101; done = 1'b0;
    reset = 1'b0;
    k = 0;
    while (!(nb >= 13 && sio_c == 1'b0) && k < 400) begin tick(1); k++; end
    check("mid_reached_slot12", nb >= 13, 1'b1);
    check("mid_busy_before", busy, 1'b1);
    reset = 1'b1;
    #1;
    check("mid_rst_bus", {sio_c, sio_d_out, sio_d_oe}, 3'b111);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_continue", cont, 1'b0);
    data = 16'h3e00;
    tick(2);
    reset = 1'b0; r = cyc;
    wait_pulses(1, exp_gap(16'h3e00) + 40, "mid_restart_pulse");
    check("mid_restart_time", pulse_at(0), r + exp_gap(16'h3e00));
    check("mid_restart_word", word_at(0), {8'h00, 8'h42, 16'h3e00});

    // Sequencer already done at release.
    do_reset();
    data = 16'hffff; done = 1'b1;
    reset = 1'b0;
    tick(2);
    check("done_cfg_cycle2", config_done, 1'b0);
    tick(1);
    check("done_cfg_cycle3", config_done, 1'b1);
    tick(400);
    check("done_edges", edges, 0);
    check("done_pulses", pulse_q.size(), 0);
    check("done_bus_idle", {sio_c, sio_d_out, sio_d_oe, busy}, 4'b1110);

    // Full 11-entry init table driven by a 2-cycle-latency sequencer model.
    do_reset();
    idx = 0; data = tbl[0]; done = 1'b0; due = -1;
    reset = 1'b0; r = cyc;
    k = 0;
    while (!config_done && k < 6000) begin
      tick(1); k++;
      if (cyc == due) begin
        idx++;
        if (idx < 11) data = tbl[idx];
        else begin data = 16'hffff; done = 1'b1; end
      end
      if (cont) due = cyc + 2;
    end
    check("seq_config_done", config_done, 1'b1);
    check("seq_pulses", pulse_q.size(), 11);
    check("seq_txns", q_word.size(), 11);
    check("seq_cfg_time", cyc, pulse_at(10) + 3);
    prev = r;
    for (int i = 0; i < 11; i++) begin
      check("seq_word", word_at(i), {8'h00, 8'h42, tbl[i]});
      check("seq_gap", pulse_at(i) - prev, exp_gap(tbl[i]));
      prev = pulse_at(i);
    end
    edges_at_end = edges;
    tick(500);
    check("seq_no_more_edges", edges, edges_at_end);
    check("seq_no_more_pulses", pulse_q.size(), 11);
    check("seq_bus_idle", {sio_c, sio_d_out, sio_d_oe, busy, config_done}, 5'b11101);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
